// File: rtl/proc_ctrl_pkg.sv
// Shared opcodes, FSM states and bus-select encodings for the processor control unit.
package proc_ctrl_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_T1   = 2'b01,
        ST_T2   = 2'b10,
        ST_T3   = 2'b11
    } state_t;

    localparam logic [5:0] SEL_NONE = 6'b000000;
    localparam logic [5:0] SEL_G    = 6'b000001;
    localparam logic [5:0] SEL_R0   = 6'b000010;
    localparam logic [5:0] SEL_R1   = 6'b000100;
    localparam logic [5:0] SEL_R2   = 6'b001000;
    localparam logic [5:0] SEL_R3   = 6'b010000;
    localparam logic [5:0] SEL_DIN  = 6'b100000;

    function automatic logic [5:0] sel_reg(input logic [1:0] idx);
        logic [5:0] sel;
        case (idx)
            2'd0:    sel = SEL_R0;
            2'd1:    sel = SEL_R1;
            2'd2:    sel = SEL_R2;
            2'd3:    sel = SEL_R3;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Bit i of the result is the write enable of register Ri.
    function automatic logic [3:0] rin_onehot(input logic [1:0] idx);
        logic [3:0] rin;
        case (idx)
            2'd0:    rin = 4'b0001;
            2'd1:    rin = 4'b0010;
            2'd2:    rin = 4'b0100;
            2'd3:    rin = 4'b1000;
            default: rin = 4'b0000;
        endcase
        return rin;
    endfunction

endpackage

// File: rtl/proc_control_unit_reg8.sv
// 8-bit register with load enable and asynchronous active-low clear.
module proc_control_unit_reg8 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);

    logic [7:0] r_q;

    // Capture i_d when enabled, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 8'h00;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle control FSM for a small mv/mvi/add/sub datapath.
// Optional build macro PROC_CTRL_INSTR_COUNT_EN adds an 8-bit completed-instruction counter.
module proc_control_unit
    import proc_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [7:0] DIN,
    output logic [5:0] S,
    output logic       R0in,
    output logic       R1in,
    output logic       R2in,
    output logic       R3in,
    output logic       Ain,
    output logic       Gin,
    output logic       Mode,
    output logic       Done,
`ifdef PROC_CTRL_INSTR_COUNT_EN
    output logic [7:0] InstrCount,
`endif
    output logic       Busy
);

    state_t     r_state;
    logic [7:0] r_ir;
    logic       w_ir_load;
    logic [1:0] w_opcode;
    logic [1:0] w_rx;
    logic [1:0] w_ry;
    logic       w_unused_ir;

    logic [5:0] w_sel;
    logic [3:0] w_rin;
    logic       w_ain;
    logic       w_gin;
    logic       w_mode;
    logic       w_done;

    assign w_ir_load   = (r_state == ST_IDLE) && Run;
    assign w_opcode    = r_ir[7:6];
    assign w_rx        = r_ir[3:2];
    assign w_ry        = r_ir[1:0];
    assign w_unused_ir = ^r_ir[5:4];

    proc_control_unit_reg8 u_ir (
        .i_clk   (Clk),
        .i_rst_n (Resetn),
        .i_en    (w_ir_load),
        .i_d     (DIN),
        .o_q     (r_ir)
    );

    // State sequencing: mv/mvi finish in T1, add/sub walk through T2 and T3.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= Run ? ST_T1 : ST_IDLE;
                ST_T1:   r_state <= (w_opcode[1] == 1'b0) ? ST_IDLE : ST_T2;
                ST_T2:   r_state <= ST_T3;
                ST_T3:   r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Control decode from state and IR only, so reset clears outputs immediately.
    always_comb begin
        w_sel  = SEL_NONE;
        w_rin  = 4'b0000;
        w_ain  = 1'b0;
        w_gin  = 1'b0;
        w_mode = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sel = SEL_NONE;
            end
            ST_T1: begin
                if (w_opcode == OP_MV) begin
                    w_sel  = sel_reg(w_ry);
                    w_rin  = rin_onehot(w_rx);
                    w_done = 1'b1;
                end else if (w_opcode == OP_MVI) begin
                    w_sel  = SEL_DIN;
                    w_rin  = rin_onehot(w_rx);
                    w_done = 1'b1;
                end else begin
                    w_sel = sel_reg(w_rx);
                    w_ain = 1'b1;
                end
            end
            ST_T2: begin
                w_sel  = sel_reg(w_ry);
                w_gin  = 1'b1;
                w_mode = r_ir[6];
            end
            ST_T3: begin
                w_sel  = SEL_G;
                w_rin  = rin_onehot(w_rx);
                w_done = 1'b1;
            end
            default: begin
                w_sel = SEL_NONE;
            end
        endcase
    end

    assign S    = w_sel;
    assign R0in = w_rin[0];
    assign R1in = w_rin[1];
    assign R2in = w_rin[2];
    assign R3in = w_rin[3];
    assign Ain  = w_ain;
    assign Gin  = w_gin;
    assign Mode = w_mode;
    assign Done = w_done;
    assign Busy = (r_state != ST_IDLE);

`ifdef PROC_CTRL_INSTR_COUNT_EN
    logic [7:0] r_instr_count;

    // Count completed instructions; wraps naturally at 8 bits.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_instr_count <= 8'h00;
        end else if (w_done) begin
            r_instr_count <= r_instr_count + 8'h01;
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign InstrCount = r_instr_count;
`endif

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: directed instructions, expected busy-cycle vectors queued.
module tb_proc_control_unit;

    logic       Clk = 1'b0;
    logic       Resetn;
    logic       Run;
    logic [7:0] DIN;
    logic [5:0] S;
    logic       R0in, R1in, R2in, R3in, Ain, Gin, Mode, Done, Busy;
`ifdef PROC_CTRL_INSTR_COUNT_EN
    logic [7:0] InstrCount;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [14:0] exp_q[$];
    logic [14:0] act;

    proc_control_unit dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .S      (S),
        .R0in   (R0in),
        .R1in   (R1in),
        .R2in   (R2in),
        .R3in   (R3in),
        .Ain    (Ain),
        .Gin    (Gin),
        .Mode   (Mode),
        .Done   (Done),
`ifdef PROC_CTRL_INSTR_COUNT_EN
        .InstrCount (InstrCount),
`endif
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;

    // {S, R3in..R0in, Ain, Gin, Mode, Done, Busy}
    assign act = {S, R3in, R2in, R1in, R0in, Ain, Gin, Mode, Done, Busy};

    function automatic logic [14:0] ev(input logic [5:0] s, input logic [3:0] r,
                                       input logic a, input logic g, input logic m, input logic d);
        return {s, r, a, g, m, d, 1'b1};
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every busy cycle must match the next queued expectation.
    always @(negedge Clk) begin
        if (Resetn === 1'b1 && Busy === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_busy: got %b expected no busy cycle at %0t", act, $time);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL busy_cycle: got %b expected %b at %0t", act, e, $time);
                end
            end
        end
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 in the following IDLE with Run low.
    task automatic run_instr(input logic [7:0] ir, input logic [7:0] imm, input logic hold, input int nbusy);
        Run = 1'b1;
        DIN = ir;
        @(negedge Clk);
        check("idle_outputs", act, 15'd0);
        @(posedge Clk); #1;
        DIN = (ir[7:6] == 2'b01) ? imm : 8'hFF;
        Run = hold;
        for (int k = 1; k < nbusy; k++) begin
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
        Run = 1'b0;
        DIN = 8'h00;
    endtask

    initial begin
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = 8'h00;
        #1;
        check("reset_state", act, 15'd0);
        repeat (2) @(posedge Clk);
        #1;
        Resetn = 1'b1;
        @(negedge Clk);
        check("post_reset_idle", act, 15'd0);
        @(posedge Clk); #1;

        // mvi R1, 0x2A
        exp_q.push_back(ev(6'b100000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h44, 8'h2A, 1'b0, 1);
        // mv R1,R2
        exp_q.push_back(ev(6'b001000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h06, 8'h00, 1'b0, 1);
        // add R0,R1
        exp_q.push_back(ev(6'b000010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ev(6'b000100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'b000001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h81, 8'h00, 1'b0, 3);
        // sub R2,R3 with Run held and DIN disturbed while busy
        exp_q.push_back(ev(6'b001000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ev(6'b010000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(ev(6'b000001, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'hCB, 8'h00, 1'b1, 3);
        // add R1,R1
        exp_q.push_back(ev(6'b000100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ev(6'b000100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'b000001, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h85, 8'h00, 1'b0, 3);
        // mv R3,R0 with reserved bits set
        exp_q.push_back(ev(6'b000010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h3C, 8'h00, 1'b1, 1);
        // mvi R0 with reserved bits set
        exp_q.push_back(ev(6'b100000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h70, 8'h55, 1'b0, 1);

        // Abort add R0,R1 during T2
        exp_q.push_back(ev(6'b000010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
        Run = 1'b1;
        DIN = 8'h81;
        @(posedge Clk); #1;
        DIN = 8'hFF;
        @(posedge Clk); #1;
        Resetn = 1'b0;
        #1;
        check("abort_immediate", act, 15'd0);
        @(negedge Clk);
        check("abort_held", act, 15'd0);
        @(posedge Clk); #1;
        Resetn = 1'b1;
        Run = 1'b0;
        DIN = 8'h00;
        @(negedge Clk);
        check("abort_release_idle", act, 15'd0);
        @(posedge Clk); #1;
        exp_q.push_back(ev(6'b000010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(ev(6'b000100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(6'b000001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h81, 8'h00, 1'b0, 3);

`ifdef PROC_CTRL_INSTR_COUNT_EN
        Resetn = 1'b0;
        #1;
        check("count_reset", {7'd0, InstrCount}, 15'd0);
        @(posedge Clk); #1;
        Resetn = 1'b1;
        for (int n = 0; n < 255; n++) begin
            exp_q.push_back(ev(6'b001000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1));
            run_instr(8'h06, 8'h00, 1'b0, 1);
        end
        check("count_255", {7'd0, InstrCount}, 15'd255);
        exp_q.push_back(ev(6'b001000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h06, 8'h00, 1'b0, 1);
        check("count_wrap", {7'd0, InstrCount}, 15'd0);
        exp_q.push_back(ev(6'b001000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1));
        run_instr(8'h06, 8'h00, 1'b0, 1);
        check("count_after_wrap", {7'd0, InstrCount}, 15'd1);
`endif

        repeat (3) @(posedge Clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_busy: %0d expected busy cycles never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/proc_control_unit.md
PROC_CONTROL_UNIT -- requirements
Module: proc_control_unit

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Resetn  input  1  asynchronous, active-low reset.
REQ-003 Run  input  1  start request; sampled only in IDLE.
REQ-004 DIN  input  8  instruction word in IDLE; immediate operand for mvi.
REQ-005 S  output  6  one-hot bus select: bit0 G, bit1 R0, bit2 R1, bit3 R2, bit4 R3, bit5 DIN.
REQ-006 R0in, R1in, R2in, R3in  output  1 each  register write enables.
REQ-007 Ain, Gin  output  1 each  A and G write enables.
REQ-008 Mode  output  1  ALU op: 0 add, 1 subtract.
REQ-009 Done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-010 Busy  output  1  high in every state except IDLE.

Function
REQ-011 Instruction format shall be IR[7:6] opcode, IR[5:4] reserved (ignored), IR[3:2] Rx, IR[1:0] Ry.
REQ-012 Opcodes shall be 00 mv Rx<-Ry; 01 mvi Rx<-DIN; 10 add Rx<-Rx+Ry; 11 sub Rx<-Rx-Ry.
REQ-013 States shall be IDLE, T1, T2, T3.
REQ-014 In IDLE with Run=1, IR shall load DIN and the state shall advance to T1 on the same edge; with Run=0 it shall stay in IDLE.
REQ-015 Run in T1..T3 shall be ignored: no IR load, no restart.
REQ-016 mv T1: S selects Ry, Rx-in=1, Done=1; next state IDLE.
REQ-017 mvi T1: S=DIN (bit5), Rx-in=1, Done=1; next state IDLE; the immediate shall be presented on DIN during T1.
REQ-018 add/sub T1: S selects Rx, Ain=1; next T2.
REQ-019 add/sub T2: S selects Ry, Gin=1, Mode=IR[6]; next T3.
REQ-020 add/sub T3: S=G (bit0), Rx-in=1, Done=1; next IDLE.
REQ-021 Latency shall be 2 cycles for mv/mvi and 4 cycles for add/sub, from the Run-sampling edge through Done, inclusive of the IDLE cycle.
REQ-022 Outputs shall be combinational decodes of state and IR only, with no dependence on Run or DIN.
REQ-023 In IDLE, S=000000 and all enables, Mode and Done shall be 0.
REQ-024 At most one Rx-in shall be high in any cycle; Mode shall be 0 outside add/sub T2.
REQ-025 Rx=Ry (for example, add R1,R1) shall be legal, with no special-casing.
REQ-026 A new instruction may be accepted in the IDLE cycle immediately following Done.

Reset
REQ-027 Resetn low shall immediately force state=IDLE and IR=0, and drive all outputs to their IDLE values, including mid-instruction.
REQ-028 An aborted instruction shall produce no Done, and no write enable shall be asserted after the reset is asserted.

Configuration
REQ-029 Macro PROC_CTRL_INSTR_COUNT_EN: when defined, the module shall add output InstrCount[7:0], which increments on each Done cycle, wraps from 255 to 0, and resets to 0.
REQ-030 Without PROC_CTRL_INSTR_COUNT_EN, the port and counter shall be absent, and all other behaviour shall be identical.

Structure
REQ-031 A shared package proc_ctrl_pkg shall hold the opcode constants, the state enum, and the S one-hot constants (SEL_G, SEL_R0..SEL_R3, SEL_DIN).
REQ-032 The IR shall be an instance of the team's 8-bit enable register with EN=(IDLE and Run); there shall be no other sub-modules.

Verification
REQ-033 Reset, then Run=1 with DIN=0x44 (mvi R1); next cycle DIN=0x2A -> T1: S=100000, R1in=1, Done=1; back to IDLE.
REQ-034 DIN=0x06 (mv R1,R2) -> T1: S=001000, R1in=1, Done=1, Busy high for exactly 1 cycle.
REQ-035 DIN=0x81 (add R0,R1) -> T1 S=000010 Ain; T2 S=000100 Gin Mode=0; T3 S=000001 R0in Done.
REQ-036 DIN=0xCB (sub R2,R3) -> T2 Mode=1; T3 R2in=1; Run held high through T1..T3 causes no IR change.
REQ-037 Resetn pulsed low during add T2 -> immediately IDLE, all outputs 0, no Done; the next Run executes normally.
REQ-038 With PROC_CTRL_INSTR_COUNT_EN defined, 256 back-to-back mv instructions -> InstrCount reads 0 and equals 1 after one more.
